// File: rtl/transmitter.sv
// UART 8N1 transmitter sharing the receiver's clk_en oversampling tick.
// A single-entry holding register behind valid/ready allows back-to-back frames.
module transmitter #(
    parameter int unsigned SAMPLE_RATE = 24,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       clk_en,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [4:0] SAMPLE_LAST = 5'(SAMPLE_RATE - 1);
    localparam logic       STOP_LAST   = 1'(STOP_BITS - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [4:0] sample_q, sample_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;

    logic       accept;
    logic       bit_end;
    logic       load;

    assign accept   = tx_valid & ~hold_full_q;
    assign bit_end  = clk_en & (sample_q == SAMPLE_LAST);

    assign tx_ready = ~hold_full_q;
    assign tx       = tx_q;
    assign busy     = busy_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        sample_d    = sample_q;
        stop_cnt_d  = stop_cnt_q;
        tx_d        = tx_q;
        load        = 1'b0;

        if (accept) begin
            hold_d      = data;
            hold_full_d = 1'b1;
        end

        if (state_q == IDLE) begin
            sample_d = '0;
        end else if (clk_en) begin
            sample_d = bit_end ? '0 : sample_q + 5'd1;
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (clk_en && hold_full_q) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                if (bit_end) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
        endcase

        // A load needs hold_full=1, so tx_ready=0 and it never coincides with an accept.
        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            tx_d        = 1'b0;
            state_d     = START;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            sample_q    <= '0;
            stop_cnt_q  <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            sample_q    <= sample_d;
            stop_cnt_q  <= stop_cnt_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_transmitter.sv
// Bench for transmitter: two instances (24x/1 stop, 8x/2 stop), each with a
// line-decoding monitor checking against a queue of bytes pushed on accept.
module tb_transmitter;

    logic       clk  = 1'b0;
    logic       rstb = 1'b0;
    logic       clk_en = 1'b0;
    logic       tx_valid [2];
    logic       tx_ready [2];
    logic [7:0] data     [2];
    logic       tx       [2];
    logic       busy     [2];

    int unsigned en_div = 1;
    int          n_cmp  = 0;
    int          n_err  = 0;
    logic [7:0]  exp0 [$];
    logic [7:0]  exp1 [$];
    int          rx_cnt   [2];
    int          last_gap [2];
    int          busy_hi  [2];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // clk_en changes just after posedge so the monitor sees the upcoming tick at negedge.
    initial begin
        int unsigned c;
        c = 0;
        forever begin
            @(posedge clk);
            #1;
            c++;
            clk_en = ((c % en_div) == 0);
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned SR = (g == 0) ? 24 : 8;
        localparam int unsigned SB = (g == 0) ? 1 : 2;

        transmitter #(
            .SAMPLE_RATE(SR),
            .STOP_BITS  (SB)
        ) u_dut (
            .clk     (clk),
            .rstb    (rstb),
            .clk_en  (clk_en),
            .tx_valid(tx_valid[g]),
            .tx_ready(tx_ready[g]),
            .data    (data[g]),
            .tx      (tx[g]),
            .busy    (busy[g])
        );

        initial begin
            bit         act;
            int         k;
            int         gap;
            int         bitn;
            logic [7:0] sh;
            act = 1'b0; k = 0; gap = 0; sh = '0;
            forever begin
                @(negedge clk);
                if (busy[g]) busy_hi[g]++;
                if (!rstb) begin
                    act = 1'b0;
                    gap = 0;
                end else begin
                    if (!act) begin
                        if (tx[g] == 1'b0) begin
                            act = 1'b1;
                            k = 0;
                            last_gap[g] = gap;
                        end else if (clk_en) begin
                            gap++;
                        end
                    end
                    if (act && clk_en) begin
                        if ((k % SR) == SR / 2) begin
                            bitn = k / SR;
                            if (bitn == 0) chk("start_bit", tx[g], 0);
                            else if (bitn <= 8) sh = {tx[g], sh[7:1]};
                            else chk("stop_bit", tx[g], 1);
                        end
                        if (k == (9 + SB) * SR - 1) begin
                            act = 1'b0;
                            gap = 0;
                            rx_cnt[g]++;
                            if (g == 0) begin
                                chk("rx0_pending", exp0.size() > 0, 1);
                                if (exp0.size() > 0) chk("rx0_byte", sh, exp0.pop_front());
                            end else begin
                                chk("rx1_pending", exp1.size() > 0, 1);
                                if (exp1.size() > 0) chk("rx1_byte", sh, exp1.pop_front());
                            end
                        end else begin
                            k++;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input int s, input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        while (!tx_ready[s] && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready_timeout", t < 20000, 1);
        tx_valid[s] = 1'b1;
        data[s]     = b;
        if (s == 0) exp0.push_back(b); else exp1.push_back(b);
        @(negedge clk);
        tx_valid[s] = 1'b0;
    endtask

    task automatic wait_idle(input int s);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy[s] || !tx_ready[s]) && t < 100000);
        chk("idle_timeout", t < 100000, 1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin
        int         low, t, idx, rises, n0, n1, busy_low;
        logic       prev;
        logic [7:0] sv [3];
        sv = '{8'h3C, 8'h3D, 8'h3E};
        rx_cnt = '{0, 0}; last_gap = '{0, 0}; busy_hi = '{0, 0};
        tx_valid = '{1'b0, 1'b0};
        data     = '{8'h00, 8'h00};

        // reset and idle
        repeat (3) @(negedge clk);
        chk("rst_tx", tx[0], 1);
        chk("rst_ready", tx_ready[0], 1);
        chk("rst_busy", busy[0], 0);
        rstb = 1'b1;
        low = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!tx[0] || !tx[1]) low++;
        end
        chk("idle_tx_low", low, 0);

        // single byte, clk_en every cycle
        busy_hi[0] = 0;
        tx_valid[0] = 1'b1;
        data[0]     = 8'hA5;
        exp0.push_back(8'hA5);
        @(negedge clk);
        tx_valid[0] = 1'b0;
        chk("a5_ready_low", tx_ready[0], 0);
        @(negedge clk);
        chk("a5_ready_back", tx_ready[0], 1);
        chk("a5_start_tx", tx[0], 0);
        chk("a5_busy", busy[0], 1);
        wait_idle(0);
        chk("a5_busy_len", busy_hi[0], 240);
        chk("a5_drained", exp0.size(), 0);

        // back-to-back, clk_en every 4th clk
        en_div = 4;
        repeat (8) @(negedge clk);
        send(0, 8'h00);
        repeat (24 * 4 * 3) @(negedge clk);
        chk("b2b_in_frame", busy[0], 1);
        send(0, 8'hFF);
        chk("b2b_ready_low", tx_ready[0], 0);
        t = 0; busy_low = 0;
        while (!tx_ready[0] && t < 5000) begin
            @(negedge clk);
            t++;
            if (!busy[0]) busy_low++;
        end
        chk("b2b_ready_held", t > 24 * 4, 1);
        @(negedge clk);
        chk("b2b_second_start", tx[0], 0);
        chk("b2b_gap", last_gap[0], 0);
        chk("b2b_busy_drop", busy_low, 0);
        wait_idle(0);
        chk("b2b_drained", exp0.size(), 0);

        // stall: valid held high with three queued bytes
        en_div = 1;
        repeat (4) @(negedge clk);
        n0 = rx_cnt[0];
        idx = 0; rises = 0; t = 0;
        prev = tx_ready[0];
        tx_valid[0] = 1'b1;
        data[0]     = sv[0];
        while ((idx < 3 || busy[0] || !tx_ready[0]) && t < 10000) begin
            if (tx_valid[0] && tx_ready[0]) begin
                exp0.push_back(data[0]);
                idx++;
            end
            @(negedge clk);
            t++;
            if (tx_ready[0] && !prev) rises++;
            prev = tx_ready[0];
            if (idx < 3) data[0] = sv[idx];
            else tx_valid[0] = 1'b0;
        end
        chk("stall_timeout", t < 10000, 1);
        chk("stall_rises", rises, 3);
        chk("stall_frames", rx_cnt[0] - n0, 3);

        // loopback: random bytes into both instances concurrently
        n0 = rx_cnt[0];
        n1 = rx_cnt[1];
        fork
            begin
                for (int i = 0; i < 256; i++) send(0, 8'($urandom));
            end
            begin
                for (int j = 0; j < 256; j++) send(1, 8'($urandom));
            end
        join
        wait_idle(0);
        wait_idle(1);
        chk("lb_cnt0", rx_cnt[0] - n0, 256);
        chk("lb_cnt1", rx_cnt[1] - n1, 256);

        // reset during bit 3 of 0x0F with a second byte held
        send(0, 8'h0F);
        send(0, 8'h77);
        repeat (24 * 4 + 8) @(negedge clk);
        chk("mid_busy", busy[0], 1);
        chk("mid_held", tx_ready[0], 0);
        rstb = 1'b0;
        #1;
        chk("mid_rst_tx", tx[0], 1);
        chk("mid_rst_busy", busy[0], 0);
        chk("mid_rst_ready", tx_ready[0], 1);
        void'(exp0.pop_back());
        void'(exp0.pop_back());
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        n0 = rx_cnt[0];
        low = 0;
        repeat (500) begin
            @(negedge clk);
            if (!tx[0] || busy[0]) low++;
        end
        chk("post_rst_quiet", low, 0);
        chk("post_rst_frames", rx_cnt[0] - n0, 0);
        send(0, 8'h5A);
        wait_idle(0);
        chk("post_rst_new", rx_cnt[0] - n0, 1);

        chk("q0_empty", exp0.size(), 0);
        chk("q1_empty", exp1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
